// File: rtl/channel_req_pkg.sv
// Shared definitions for the channel request latch: channel count,
// index width and the offer FSM state encoding.
package channel_req_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int IDX_W        = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/req_edge_detect.sv
// Per-channel set-event generator. Keeps a one-cycle delayed copy of the
// raw request lines (req_d) and produces the set-event vector:
//   EDGE_MODE=1 : rising edge (req high now, low last cycle)
//   EDGE_MODE=0 : level (req high)
// req_d tracks req unconditionally so that edges seen while captures are
// disabled are consumed rather than replayed later.
module req_edge_detect
  import channel_req_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] req,
  output logic [NUM_CHANNELS-1:0] set_evt
);

  logic [NUM_CHANNELS-1:0] req_d;
  logic [NUM_CHANNELS-1:0] edge_mask;

  // Delay register; cleared by reset so a line already high after reset
  // is seen as a fresh rising edge.
  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_d <= '0;
    else     req_d <= req;
  end

  // In level mode the history is ignored; in edge mode it suppresses
  // lines that were already high last cycle.
  assign edge_mask = (EDGE_MODE != 0) ? req_d : '0;
  assign set_evt   = req & ~edge_mask;

endmodule

// File: rtl/channel_request_latch.sv
// Channel request latch: captures per-channel request events into a
// sticky pending vector and offers the highest-index eligible channel to a
// consumer through a valid/ack handshake (two-state IDLE/OFFER FSM).
//
// Optional feature: define CHANNEL_REQUEST_LATCH_MASK_EN to add a writable
// mask register (ports mask_wr / mask_data). A masked channel keeps its
// pending bit but is not offered. Without the macro every channel is
// eligible and the mask ports do not exist.
module channel_request_latch
  import channel_req_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] req,
`ifdef CHANNEL_REQUEST_LATCH_MASK_EN
  input  logic                    mask_wr,
  input  logic [NUM_CHANNELS-1:0] mask_data,
`endif
  output logic [NUM_CHANNELS-1:0] pending,
  output logic                    sel_valid,
  output logic [IDX_W-1:0]        sel_idx,
  input  logic                    sel_ack
);

  logic [NUM_CHANNELS-1:0] set_evt;
  logic [NUM_CHANNELS-1:0] mask;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] clr_vec;
  logic [IDX_W-1:0]        hi_idx;
  logic                    hi_any;
  state_e                  state;

  req_edge_detect #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .set_evt (set_evt)
  );

`ifdef CHANNEL_REQUEST_LATCH_MASK_EN
  // Mask register: loaded by the write strobe, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask <= '0;
    else if (mask_wr) mask <= mask_data;
  end
`else
  assign mask = '0;
`endif

  // Masking only gates eligibility; pending bits are never touched by it.
  assign eligible = pending & ~mask;

  // Highest-index eligible channel (bit 7 has top priority).
  // NOTE: every output of a combinational block gets a default before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    hi_idx = '0;
    hi_any = |eligible;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (eligible[i]) hi_idx = IDX_W'(i);
    end
  end

  // One-hot clear of the offered channel when the consumer accepts it.
  always_comb begin
    clr_vec = '0;
    if (state == OFFER && sel_ack) clr_vec[sel_idx] = 1'b1;
  end

  // Sticky pending vector; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | (enable ? set_evt : '0);
  end

  // Offer FSM with registered sel_valid/sel_idx; the offered index is
  // frozen for the whole OFFER state and only released by sel_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && hi_any) begin
            state     <= OFFER;
            sel_valid <= 1'b1;
            sel_idx   <= hi_idx;
          end
        end
        OFFER: begin
          if (sel_ack) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
